// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero resolves in a single cycle with quotient all ones.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [3:0]       dest_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       dest_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [3:0]       dest_q, dest_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [3:0]       dest_out_q, dest_out_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] work_shift;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    dest_d      = dest_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dest_out_d  = dest_out_q;
    dbz_d       = dbz_q;

    accept = start && (Op == 2'b11) && (state_q != RUN);
    // work_q holds the remaining dividend bits on the left, quotient bits enter on the right
    shifted    = (rem_q << 1) | {{WIDTH{1'b0}}, work_q[WIDTH-1]};
    ge         = (shifted >= {1'b0, divisor_q});
    trial      = ge ? (shifted - {1'b0, divisor_q}) : shifted;
    work_shift = {work_q[WIDTH-2:0], ge};

    case (state_q)
      RUN: begin
        rem_d  = trial;
        work_d = work_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = work_shift;
          remainder_d = trial[WIDTH-1:0];
          dest_out_d  = dest_q;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          dest_d = dest_in;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dest_out_d  = dest_in;
            dbz_d       = 1'b1;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            rem_d     = '0;
            work_d    = dividend;
            divisor_d = divisor;
            dbz_d     = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      dest_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dest_out_q  <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      divisor_q   <= divisor_d;
      dest_q      <= dest_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dest_out_q  <= dest_out_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign dest_out    = dest_out_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: each task drives one scenario and checks
// outputs one cycle at a time against hand-computed values.
module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  Op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [3:0]  dest_in;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [3:0]  dest_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .Op(Op),
    .dividend(dividend), .divisor(divisor), .dest_in(dest_in),
    .quotient(quotient), .remainder(remainder), .dest_out(dest_out),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
    start = 1'b1; Op = 2'b11; dividend = a; divisor = b; dest_in = d;
    tick();
    start = 1'b0; Op = 2'b00;
  endtask

  // Counts cycles from the current one until done is seen, bounded at 100.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b dbz=%b want 000", busy, done, div_by_zero);
    end
    checks++;
    if ({quotient, remainder, dest_out} !== 68'd0) begin
      errors++; $display("FAIL reset_data got q=%h r=%h d=%h want 0", quotient, remainder, dest_out);
    end
    rst = 1'b0;
    tick();
    $display("reset: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
  endtask

  task automatic test_basic();
    int n;
    accept(32'd100, 32'd7, 4'h3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL basic_latency got %0d want 32", n);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || dest_out !== 4'h3 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d d=%h dbz=%b busy=%b want 14 2 3 0 0",
                         quotient, remainder, dest_out, div_by_zero, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      errors++; $display("FAIL basic_pulse got done=%b q=%0d want 0 14", done, quotient);
    end
    $display("100/7: cycles=%0d q=%0d r=%0d dest=%h", n, quotient, remainder, dest_out);
  endtask

  task automatic test_back_to_back();
    int n;
    accept(32'hFFFFFFFF, 32'd1, 4'hA);
    wait_done(n);
    checks++;
    if (n !== 32 || quotient !== 32'hFFFFFFFF || remainder !== 32'd0 || dest_out !== 4'hA) begin
      errors++; $display("FAIL b2b_first got n=%0d q=%h r=%h d=%h want 32 ffffffff 0 a", n, quotient, remainder, dest_out);
    end
    accept(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hB);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || quotient !== 32'hFFFFFFFF || dest_out !== 4'hA) begin
      errors++; $display("FAIL b2b_restart got done=%b busy=%b q=%h d=%h want 0 1 ffffffff a", done, busy, quotient, dest_out);
    end
    wait_done(n);
    checks++;
    if (n !== 32 || quotient !== 32'd1 || remainder !== 32'd0 || dest_out !== 4'hB) begin
      errors++; $display("FAIL b2b_second got n=%0d q=%h r=%h d=%h want 32 1 0 b", n, quotient, remainder, dest_out);
    end
    $display("back-to-back: second cycles=%0d q=%h r=%h", n, quotient, remainder);
    tick();
  endtask

  task automatic test_div_zero();
    int busy_seen;
    busy_seen = 0;
    accept(32'd5, 32'd0, 4'h7);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 32'hFFFFFFFF || remainder !== 32'd5 ||
        div_by_zero !== 1'b1 || dest_out !== 4'h7) begin
      errors++; $display("FAIL divzero_result got done=%b busy=%b q=%h r=%0d dbz=%b d=%h want 1 0 ffffffff 5 1 7",
                         done, busy, quotient, remainder, div_by_zero, dest_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
    end
    checks++;
    if (done !== 1'b0 || busy_seen !== 0 || div_by_zero !== 1'b1 || remainder !== 32'd5) begin
      errors++; $display("FAIL divzero_after got done=%b busy_seen=%0d dbz=%b r=%0d want 0 0 1 5",
                         done, busy_seen, div_by_zero, remainder);
    end
    $display("5/0: q=%h r=%0d dbz=%b", quotient, remainder, div_by_zero);
  endtask

  task automatic test_ignored();
    int n;
    start = 1'b1; Op = 2'b01; dividend = 32'd9; divisor = 32'd4; dest_in = 4'h1;
    tick();
    start = 1'b0; Op = 2'b00;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL ignore_op got busy=%b done=%b dbz=%b q=%h want 0 0 1 ffffffff",
                         busy, done, div_by_zero, quotient);
    end
    accept(32'd7, 32'd2, 4'h5);
    checks++;
    if (busy !== 1'b1 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL ignore_accept got busy=%b dbz=%b want 1 0", busy, div_by_zero);
    end
    start = 1'b1; Op = 2'b11; dividend = 32'd100; divisor = 32'd3; dest_in = 4'hE;
    tick(); tick(); tick();
    start = 1'b0; Op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    wait_done(n);
    checks++;
    if (n + 3 !== 32 || quotient !== 32'd3 || remainder !== 32'd1 || dest_out !== 4'h5) begin
      errors++; $display("FAIL ignore_run got n=%0d q=%0d r=%0d d=%h want 32 3 1 5", n + 3, quotient, remainder, dest_out);
    end
    $display("7/2 with ignored starts: cycles=%0d q=%0d r=%0d", n + 3, quotient, remainder);
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    accept(32'd1000, 32'd10, 4'h9);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_running got busy=%b want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || dest_out !== 4'h0) begin
      errors++; $display("FAIL abort_reset got busy=%b done=%b dbz=%b q=%h r=%h d=%h want all 0",
                         busy, done, div_by_zero, quotient, remainder, dest_out);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_quiet got %0d active cycles want 0", done_seen);
    end
    $display("abort: active cycles after reset=%0d", done_seen);
  endtask

  task automatic test_small_dividend();
    int n;
    accept(32'd3, 32'd10, 4'h2);
    wait_done(n);
    checks++;
    if (n !== 32 || quotient !== 32'd0 || remainder !== 32'd3 || dest_out !== 4'h2) begin
      errors++; $display("FAIL small_result got n=%0d q=%0d r=%0d d=%h want 32 0 3 2", n, quotient, remainder, dest_out);
    end
    $display("3/10: cycles=%0d q=%0d r=%0d", n, quotient, remainder);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; Op = 2'b00;
    dividend = '0; divisor = '0; dest_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignored();
    test_abort();
    test_small_dividend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
